bullet_scheduler: RTL
=====================

Name: bullet_scheduler

Overview:
- Owns a shared pool of bullet slots and allocates it between the two tank players.
- Converts shoot buttons into spawns with round-robin arbitration, a per-player cap and a per-player cooldown.
- Advances every live bullet on the game tick and retires bullets on collision or when they leave the screen.
- Sits beside player_rgb: consumes player position and facing direction; feeds bullet positions to the pixel/collision logic, which reports hits back.

Parameters:
- NUM_SLOTS, 4: total bullet slots, shared by both players.
- MAX_PER_PLAYER, 2: maximum simultaneously active bullets per player.
- BULLET_SPEED, 2: pixels moved per tick_i.
- COOLDOWN_TICKS, 16: tick_i count after a grant during which that player cannot fire.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.

Ports:
- clk_i  in  1  pixel clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle strobe at the game step rate.
- player_1_shoot_i, player_2_shoot_i  in  1 each  level shoot buttons.
- player_1_x_i, player_1_y_i, player_2_x_i, player_2_y_i  in  10 each  tank upper-left corner.
- player_1_dir_i, player_2_dir_i  in  4 each  one-hot facing: 0001 down, 0010 up, 0100 right, 1000 left.
- retire_valid_i  in  1  collision logic requests that a slot be freed.
- retire_slot_i  in  $clog2(NUM_SLOTS)  index of the slot to free.
- slot_active_o  out  NUM_SLOTS  slot is live.
- slot_owner_o  out  NUM_SLOTS  owner of each slot: 0 = player 1, 1 = player 2.
- bullet_x_o, bullet_y_o  out  NUM_SLOTS*10 each  packed positions; slot k occupies bits [10k+9:10k].
- fire_grant_o  out  2  one-cycle pulse per player on spawn; bit0 = player 1.

Behaviour:
- Reset: all slots FREE. slot_active_o, slot_owner_o, positions and fire_grant_o are 0. Cooldown counters are 0. Round-robin pointer selects player 1. Shoot history registers are 0, so a shoot input held high through reset counts as a rising edge on the first sample after reset.
- Reset takes effect mid-flight: live bullets and pending requests are discarded.
- Per-player request FSM:
  - IDLE: a rising edge on shoot goes to PENDING. The edge is registered, so it is seen one cycle after the input rises.
  - PENDING: stays here until granted.
  - On grant: goes to COOLDOWN and loads COOLDOWN_TICKS.
  - COOLDOWN: the counter decrements on each tick_i; at 0 it returns to IDLE. Shoot edges arriving in COOLDOWN are dropped, not queued.
- A PENDING request is eligible only when the player's dir is one-hot, the player's active count is below MAX_PER_PLAYER, and at least one slot is FREE.
- Arbitration:
  - At most one grant per cycle.
  - If both players are eligible, the player named by the round-robin pointer wins; the pointer then flips to the other player.
  - A single eligible player wins regardless of the pointer, and the pointer still flips.
- Slot choice: the lowest-index FREE slot, as sampled at the start of the cycle. A slot retired in the same cycle becomes available on the next cycle.
- Spawn position, using 11-bit arithmetic:
  - Centre is cx = x+15, cy = y+15.
  - Down: cy+16. Up: cy-16. Right: cx+16. Left: cx-16.
  - An off-screen spawn result is still granted; that bullet retires on its first tick.
- Latency: shoot rises before edge N → PENDING after edge N → slot active, position valid and fire_grant_o pulsing after edge N+1.
- Per-slot FSM: FREE → FLYING on grant, latching owner, direction and spawn position.
- Movement on tick_i: each FLYING slot steps BULLET_SPEED along its direction.
  - The next position is computed in 11-bit signed arithmetic.
  - If next x < 0, x > SCREEN_W-1, y < 0 or y > SCREEN_H-1, the slot goes FREE instead of moving. Positions never wrap.
- Retire:
  - retire_valid_i on a FLYING slot sets it FREE on the next edge. This has priority over a tick move in the same cycle.
  - A retire on a FREE slot is ignored.
- A grant and tick_i in the same cycle: the new bullet does not move until the next tick.
- Per-player active count is computed combinationally from slot_active_o and slot_owner_o.

Decomposition:
- tank_pkg holds:
  - the direction enum (DIR_DOWN=4'b0001, DIR_UP=4'b0010, DIR_RIGHT=4'b0100, DIR_LEFT=4'b1000);
  - TANK_SIZE=32;
  - SCREEN_W and SCREEN_H defaults;
  - the request-FSM state typedef {REQ_IDLE, REQ_PENDING, REQ_COOLDOWN}.
- Sub-module bullet_slot: one slot's FREE/FLYING FSM, latched owner and direction, position step and bounds check. It is instantiated NUM_SLOTS times.
- Arbitration and the request FSMs stay in bullet_scheduler.

Test Plan:
1. Player 1 at (224,32), dir 0001, shoot rises → after 2 cycles: slot 0 active, owner 0, position (239,63), fire_grant_o=01 for one cycle.
2. Both players PENDING in the same cycle right after reset → player 1 is granted into slot 0. Player 2 is granted the next cycle into slot 1, with its spawn position taken from its own x/y/dir.
3. Player 1 fires three times, each after its cooldown expires, with no retires → only 2 slots are active for owner 0. The third request stays PENDING; it is granted the cycle after retire_valid_i frees one of player 1's slots.
4. A bullet at y=3 moving up with BULLET_SPEED=2: tick → y=1; next tick → slot FREE and slot_active_o bit drops.
5. retire_valid_i and tick_i hit the same slot in the same cycle → slot is FREE and its position is not updated.
6. Shoot edge 5 ticks after a grant (COOLDOWN_TICKS=16) → no grant, ever. An edge after the 16th tick → granted.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank game blocks: facing directions, tank and
// screen geometry defaults, the per-player request FSM states, and the
// helpers that turn a tank position and facing into a bullet spawn point.
// No ports (package).
package tank_pkg;

  localparam int TANK_SIZE    = 32;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef enum logic [3:0] {
    DIR_DOWN  = 4'b0001,
    DIR_UP    = 4'b0010,
    DIR_RIGHT = 4'b0100,
    DIR_LEFT  = 4'b1000
  } dir_e;

  typedef enum logic [1:0] {
    REQ_IDLE     = 2'd0,
    REQ_PENDING  = 2'd1,
    REQ_COOLDOWN = 2'd2
  } req_state_e;

  // A facing is usable only when exactly one direction bit is set.
  function automatic logic dir_is_onehot(input logic [3:0] dir);
    return (dir == DIR_DOWN) || (dir == DIR_UP) ||
           (dir == DIR_RIGHT) || (dir == DIR_LEFT);
  endfunction

  // Spawn column: tank centre, pushed half a tank outward horizontally.
  function automatic logic [10:0] spawn_x(input logic [9:0] x, input logic [3:0] dir);
    logic [10:0] cx;
    cx = {1'b0, x} + 11'(TANK_SIZE / 2 - 1);
    case (dir)
      DIR_RIGHT: return cx + 11'(TANK_SIZE / 2);
      DIR_LEFT:  return cx - 11'(TANK_SIZE / 2);
      default:   return cx;
    endcase
  endfunction

  // Spawn row: tank centre, pushed half a tank outward vertically.
  function automatic logic [10:0] spawn_y(input logic [9:0] y, input logic [3:0] dir);
    logic [10:0] cy;
    cy = {1'b0, y} + 11'(TANK_SIZE / 2 - 1);
    case (dir)
      DIR_DOWN: return cy + 11'(TANK_SIZE / 2);
      DIR_UP:   return cy - 11'(TANK_SIZE / 2);
      default:  return cy;
    endcase
  endfunction

endpackage

// File: rtl/bullet_scheduler_if.sv
// Bus between the bullet scheduler and the pixel/collision logic.
//   slot_active_o / slot_owner_o : per-slot live flag and owner (0 = player 1)
//   bullet_x_o / bullet_y_o      : packed 10-bit positions, slot k at [10k+9:10k]
//   retire_valid_i / retire_slot_i : collision logic asks for a slot to be freed
// master = scheduler side, slave = collision side.
interface bullet_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [NUM_SLOTS-1:0]         slot_active_o;
  logic [NUM_SLOTS-1:0]         slot_owner_o;
  logic [NUM_SLOTS*10-1:0]      bullet_x_o;
  logic [NUM_SLOTS*10-1:0]      bullet_y_o;
  logic                         retire_valid_i;
  logic [$clog2(NUM_SLOTS)-1:0] retire_slot_i;

  modport master (
    output slot_active_o, slot_owner_o, bullet_x_o, bullet_y_o,
    input  retire_valid_i, retire_slot_i
  );

  modport slave (
    input  slot_active_o, slot_owner_o, bullet_x_o, bullet_y_o,
    output retire_valid_i, retire_slot_i
  );
endinterface

// File: rtl/bullet_scheduler_slot.sv
// bullet_slot: one bullet slot. FREE until spawned, then FLYING with a latched
// owner, direction and 11-bit signed position; steps on each tick and frees
// itself when retired or when the step would leave the screen.
// Ports: clk_i, reset_i, tick_i, spawn_i + spawn_{owner,dir,x,y}_i, retire_i,
//        active_o, owner_o, x_o, y_o (low 10 bits of the position).
module bullet_slot
  import tank_pkg::*;
#(
  parameter int BULLET_SPEED = 2,
  parameter int SCREEN_W     = tank_pkg::SCREEN_W_DEF,
  parameter int SCREEN_H     = tank_pkg::SCREEN_H_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic        spawn_i,
  input  logic        spawn_owner_i,
  input  logic [3:0]  spawn_dir_i,
  input  logic [10:0] spawn_x_i,
  input  logic [10:0] spawn_y_i,
  input  logic        retire_i,
  output logic        active_o,
  output logic        owner_o,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o
);

  localparam logic [0:0]  SLOT_FREE   = 1'b0;
  localparam logic [0:0]  SLOT_FLYING = 1'b1;
  localparam logic [10:0] STEP        = 11'(BULLET_SPEED);
  localparam logic [10:0] X_MAX       = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_MAX       = 11'(SCREEN_H - 1);

  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  dir_q, dir_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] nx_s, ny_s;
  logic        leave_s;

  // Bit 10 is the sign; a non-negative value can then be compared unsigned.
  function automatic logic on_screen(input logic [10:0] x, input logic [10:0] y);
    return !x[10] && !y[10] && (x <= X_MAX) && (y <= Y_MAX);
  endfunction

  // Candidate next position one step along the latched direction.
  always_comb begin
    nx_s = x_q;
    ny_s = y_q;
    case (dir_q)
      DIR_DOWN:  ny_s = y_q + STEP;
      DIR_UP:    ny_s = y_q - STEP;
      DIR_RIGHT: nx_s = x_q + STEP;
      DIR_LEFT:  nx_s = x_q - STEP;
      default: begin
        nx_s = x_q;
        ny_s = y_q;
      end
    endcase
  end

  // An off-screen spawn is caught here too, so it frees on its first tick.
  assign leave_s = !on_screen(nx_s, ny_s) || !on_screen(x_q, y_q);

  // Slot FSM next state; retire outranks a tick move.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      SLOT_FREE: begin
        if (spawn_i) begin
          state_d = SLOT_FLYING;
          owner_d = spawn_owner_i;
          dir_d   = spawn_dir_i;
          x_d     = spawn_x_i;
          y_d     = spawn_y_i;
        end else begin
          state_d = SLOT_FREE;
        end
      end
      SLOT_FLYING: begin
        if (retire_i) begin
          state_d = SLOT_FREE;
        end else if (tick_i) begin
          if (leave_s) begin
            state_d = SLOT_FREE;
          end else begin
            x_d = nx_s;
            y_d = ny_s;
          end
        end else begin
          state_d = SLOT_FLYING;
        end
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  // Slot state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SLOT_FREE;
      owner_q <= 1'b0;
      dir_q   <= 4'b0000;
      x_q     <= 11'd0;
      y_q     <= 11'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign active_o = (state_q == SLOT_FLYING);
  assign owner_o  = owner_q;
  assign x_o      = x_q[9:0];
  assign y_o      = y_q[9:0];

endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: shares NUM_SLOTS bullet slots between two players.
// Per-player request FSM (IDLE/PENDING/COOLDOWN) turns shoot edges into
// requests; a round-robin arbiter grants at most one per cycle into the
// lowest free slot, subject to a per-player cap.
// Ports: clk_i, reset_i (sync, active high), tick_i, player_{1,2}_{shoot,x,y,dir}_i,
//        fire_grant_o (bit0 = player 1), bus (slot status/positions out, retire in).
module bullet_scheduler
  import tank_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int BULLET_SPEED   = 2,
  parameter int COOLDOWN_TICKS = 16,
  parameter int SCREEN_W       = tank_pkg::SCREEN_W_DEF,
  parameter int SCREEN_H       = tank_pkg::SCREEN_H_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 player_1_shoot_i,
  input  logic                 player_2_shoot_i,
  input  logic [9:0]           player_1_x_i,
  input  logic [9:0]           player_1_y_i,
  input  logic [9:0]           player_2_x_i,
  input  logic [9:0]           player_2_y_i,
  input  logic [3:0]           player_1_dir_i,
  input  logic [3:0]           player_2_dir_i,
  output logic [1:0]           fire_grant_o,
  bullet_scheduler_if.master   bus
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(COOLDOWN_TICKS + 1);
  localparam int ACT_W  = $clog2(NUM_SLOTS + 1);

  logic [1:0]        shoot_s;
  logic [1:0][3:0]   dir_s;
  logic [1:0][9:0]   px_s, py_s;
  logic [1:0]        shoot_q;
  req_state_e        req_q [2];
  req_state_e        req_d [2];
  logic [CNT_W-1:0]  cd_q [2];
  logic [CNT_W-1:0]  cd_d [2];
  logic              rr_q, rr_d;
  logic [1:0]        fire_grant_q;
  logic [NUM_SLOTS-1:0] active_s, owner_s;
  logic [ACT_W-1:0]  act_cnt_s [2];
  logic              any_free_s;
  logic [SLOT_W-1:0] free_idx_s;
  logic [1:0]        eligible_s, grant_vec_s;
  logic              grant_any_s, win_s;
  logic [10:0]       spawn_x_s, spawn_y_s;

  assign shoot_s = {player_2_shoot_i, player_1_shoot_i};
  assign dir_s   = {player_2_dir_i, player_1_dir_i};
  assign px_s    = {player_2_x_i, player_1_x_i};
  assign py_s    = {player_2_y_i, player_1_y_i};

  // Live-bullet count per owner and lowest free slot, from registered slot state.
  always_comb begin
    act_cnt_s[0] = '0;
    act_cnt_s[1] = '0;
    free_idx_s   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      act_cnt_s[0] = act_cnt_s[0] + ACT_W'(active_s[k] & ~owner_s[k]);
      act_cnt_s[1] = act_cnt_s[1] + ACT_W'(active_s[k] & owner_s[k]);
    end
    // Descending scan so the lowest free index is the last one written.
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      free_idx_s = active_s[k] ? free_idx_s : SLOT_W'(k);
    end
  end

  assign any_free_s = ~&active_s;

  // Eligibility and round-robin pick of the single winner this cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      eligible_s[p] = (req_q[p] == REQ_PENDING) && dir_is_onehot(dir_s[p]) &&
                      (act_cnt_s[p] < ACT_W'(MAX_PER_PLAYER)) && any_free_s;
    end
    grant_any_s = |eligible_s;
    win_s       = (&eligible_s) ? rr_q : eligible_s[1];
    grant_vec_s = grant_any_s ? (win_s ? 2'b10 : 2'b01) : 2'b00;
    spawn_x_s   = spawn_x(px_s[win_s], dir_s[win_s]);
    spawn_y_s   = spawn_y(py_s[win_s], dir_s[win_s]);
    rr_d        = grant_any_s ? ~rr_q : rr_q;
  end

  // Request FSMs; edges seen in COOLDOWN are dropped, not queued.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_d[p] = req_q[p];
      cd_d[p]  = cd_q[p];
      case (req_q[p])
        REQ_IDLE: begin
          if (shoot_s[p] && !shoot_q[p]) req_d[p] = REQ_PENDING;
          else                           req_d[p] = REQ_IDLE;
        end
        REQ_PENDING: begin
          if (grant_vec_s[p]) begin
            req_d[p] = REQ_COOLDOWN;
            cd_d[p]  = CNT_W'(COOLDOWN_TICKS);
          end else begin
            req_d[p] = REQ_PENDING;
          end
        end
        REQ_COOLDOWN: begin
          if (tick_i) begin
            cd_d[p] = cd_q[p] - CNT_W'(1);
            if (cd_q[p] <= CNT_W'(1)) req_d[p] = REQ_IDLE;
            else                      req_d[p] = REQ_COOLDOWN;
          end else begin
            req_d[p] = REQ_COOLDOWN;
          end
        end
        default: req_d[p] = REQ_IDLE;
      endcase
    end
  end

  // Scheduler registers: shoot history, request FSMs, pointer, grant pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shoot_q      <= 2'b00;
      rr_q         <= 1'b0;
      fire_grant_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        req_q[p] <= REQ_IDLE;
        cd_q[p]  <= '0;
      end
    end else begin
      shoot_q      <= shoot_s;
      rr_q         <= rr_d;
      fire_grant_q <= grant_vec_s;
      for (int p = 0; p < 2; p++) begin
        req_q[p] <= req_d[p];
        cd_q[p]  <= cd_d[p];
      end
    end
  end

  assign fire_grant_o = fire_grant_q;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    bullet_slot #(
      .BULLET_SPEED (BULLET_SPEED),
      .SCREEN_W     (SCREEN_W),
      .SCREEN_H     (SCREEN_H)
    ) u_slot (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .tick_i        (tick_i),
      .spawn_i       (grant_any_s && (free_idx_s == SLOT_W'(k))),
      .spawn_owner_i (win_s),
      .spawn_dir_i   (dir_s[win_s]),
      .spawn_x_i     (spawn_x_s),
      .spawn_y_i     (spawn_y_s),
      .retire_i      (bus.retire_valid_i && (bus.retire_slot_i == SLOT_W'(k))),
      .active_o      (active_s[k]),
      .owner_o       (owner_s[k]),
      .x_o           (bus.bullet_x_o[10*k +: 10]),
      .y_o           (bus.bullet_y_o[10*k +: 10])
    );
  end

  assign bus.slot_active_o = active_s;
  assign bus.slot_owner_o  = owner_s;

endmodule
